spi_master_rw: RTL and testbench
================================

Name: spi_master_rw

Overview:
- Single-byte SPI register-access master: a 16-bit frame per transaction, consisting of a R/W bit, a 7-bit address and an 8-bit data byte.
- Separate write and read start strobes; the serial clock rate is programmable via `freq`.
- Sits between a local controller and one external SPI slave device; read data is returned on `rdata` with a one-cycle `done` pulse.

Parameters:
- None. All widths are fixed; the divider is runtime-programmable via `freq`.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  reset, synchronous, active-high
- freq  input  8  SCK half-period select; half-period H = freq+1 clk cycles; sampled at transaction start
- start_w  input  1  write request; level input, rising edge triggers
- start_r  input  1  read request; level input, rising edge triggers
- addr  input  7  target register address; sampled at transaction start
- wdata  input  8  write data; sampled at transaction start
- rdata  output  8  last read byte; holds until the next read completes
- done  output  1  one-cycle pulse at the end of every transaction
- ss  output  1  slave select, active-low
- sck  output  1  serial clock, idle low
- mosi  output  1  serial data out, MSB first
- miso  input  1  serial data in

Behaviour:
- Reset: clocked while rst=1. Values: ss=1, sck=0, mosi=0, done=0, rdata=0x00, state=IDLE, start edge-detect registers=0, divider counter=0.
- Start detection:
  - Rising edge = start registered high this cycle and low the previous cycle.
  - A start already high when reset releases counts as an edge.
  - A strobe held high for many cycles gives exactly one transaction.
- Edge priority and busy:
  - Start edges are ignored outside IDLE; they are not queued.
  - If start_w and start_r both rise in the same cycle, the read wins.
- Frame at the edge: frame = {rw, addr[6:0], data[7:0]}.
  - rw=0 for write, 1 for read.
  - data=wdata for a write, 0x00 for a read.
  - freq is latched into H at the same time.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, 16 SCK pulses per frame.
- States: IDLE, SETUP, SCK_HIGH, SCK_LOW, HOLD.
- IDLE:
  - On a start edge in cycle T, go to SETUP.
  - From cycle T+1: ss=0, mosi=frame[15].
- SETUP: after H cycles, sck=1 and go to SCK_HIGH.
- SCK_HIGH:
  - On each sck rising edge the master samples miso into a shift register.
  - After H cycles, sck=0.
  - If fewer than 16 bits are done, mosi advances to the next bit on this falling edge and the state goes to SCK_LOW.
  - Otherwise the state goes to HOLD and mosi is held.
- SCK_LOW: after H cycles, sck=1 and go to SCK_HIGH.
- HOLD: after H cycles:
  - ss=1 and mosi=0.
  - done=1 for exactly one cycle.
  - For a read only, rdata is loaded with the last 8 sampled bits (the bits sampled on rising edges 9..16).
  - Go to IDLE.
- Timing:
  - ss is low for exactly 33*H clk cycles.
  - sck high and low phases are each exactly H cycles.
  - A new start edge is accepted in the cycle after done.
- Writes do not modify rdata.
- freq changes during a transaction have no effect.
- freq=0 gives H=1 (SCK = clk/2); freq=255 gives H=256.
- Reset mid-transaction:
  - The frame is aborted immediately on the next clk edge.
  - Outputs return to their reset values; no done pulse is generated.
  - rdata is cleared.
- done is never asserted outside HOLD completion.
- sck never toggles while ss=1.

Test Plan:
- rst=1 for several cycles, then release with starts low -> ss=1, sck=0, mosi=0, done=0, rdata=0x00; no activity.
- freq=4, addr=0x2A, wdata=0xA5, start_w held high for 10 cycles -> exactly one frame.
  - mosi bits on the sck rising edges = 0010101010100101 (0x2AA5).
  - 16 sck pulses of 5 cycles high / 5 cycles low; ss low 165 cycles.
  - One done pulse; rdata stays 0x00.
- freq=4, addr=0x15, miso=0, start_r pulse -> mosi frame 0x9500; done pulses once; rdata=0x00.
- freq=0, addr=0x7F, slave model drives miso=0x3C on the data byte (changing on sck falling edges), start_r -> mosi frame 0xFF00; rdata=0x3C at done; ss low 33 cycles.
- A start_w edge arriving mid-read is ignored; start_w and start_r rising in the same cycle give a read frame (rw=1).
- rst=1 asserted at the 5th sck pulse -> next cycle ss=1, sck=0, no done.
  - A following write then completes normally.

Source files
------------

// File: rtl/spi_master_rw.sv
// spi_master_rw
//   Single-byte SPI register-access master (mode 0, MSB first). Each
//   transaction shifts one 16-bit frame {rw, addr[6:0], data[7:0]} to an
//   external slave. A read returns the slave's data byte on rdata.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   freq     in   SCK half-period select, H = freq+1 clk cycles (latched at start)
//   start_w  in   write request, rising edge triggers
//   start_r  in   read request, rising edge triggers (wins over start_w)
//   addr     in   7-bit register address (latched at start)
//   wdata    in   write data byte (latched at start)
//   rdata    out  last read byte, held until the next read completes
//   done     out  one-cycle pulse at the end of every transaction
//   ss       out  slave select, active-low
//   sck      out  serial clock, idle low
//   mosi     out  serial data out
//   miso     in   serial data in
module spi_master_rw (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] freq,
  input  logic       start_w,
  input  logic       start_r,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HIGH,
    SCK_LOW,
    HOLD
  } state_t;

  // Control state
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bits_q, bits_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        ss_q, ss_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        sw_q, sr_q;

  // Per-transaction data (no reset needed; always loaded before use)
  logic [7:0]  h_q, h_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;

  logic        edge_w, edge_r, phase_end;
  logic [15:0] frame_new;

  // The edge registers follow the inputs in every state, so a held strobe
  // yields a single edge and edges seen while busy are simply dropped.
  assign edge_w    = start_w & ~sw_q;
  assign edge_r    = start_r & ~sr_q;
  assign phase_end = (cnt_q == h_q);
  assign frame_new = edge_r ? {1'b1, addr, 8'h00} : {1'b0, addr, wdata};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    ss_d    = ss_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    h_d     = h_q;
    frame_d = frame_q;
    rx_d    = rx_q;
    rw_d    = rw_q;

    if (state_q != IDLE) begin
      cnt_d = phase_end ? 8'd0 : cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (edge_w || edge_r) begin
          rw_d    = edge_r;
          h_d     = freq;
          ss_d    = 1'b0;
          mosi_d  = frame_new[15];
          // frame_q[15] always holds the next bit to present on mosi
          frame_d = {frame_new[14:0], 1'b0};
          bits_d  = 5'd0;
          state_d = SETUP;
        end
      end
      SETUP, SCK_LOW: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], miso};
          bits_d  = bits_q + 5'd1;
          state_d = SCK_HIGH;
        end
      end
      SCK_HIGH: begin
        if (phase_end) begin
          sck_d = 1'b0;
          if (bits_q != 5'd16) begin
            mosi_d  = frame_q[15];
            frame_d = {frame_q[14:0], 1'b0};
            state_d = SCK_LOW;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          // rx_q holds exactly the samples of rising edges 9..16 here
          if (rw_q) rdata_d = rx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bits_q  <= 5'd0;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      ss_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      sw_q    <= 1'b0;
      sr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      ss_q    <= ss_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      sw_q    <= start_w;
      sr_q    <= start_r;
    end
  end

  always_ff @(posedge clk) begin
    h_q     <= h_d;
    frame_q <= frame_d;
    rx_q    <= rx_d;
    rw_q    <= rw_d;
  end

  assign rdata = rdata_q;
  assign done  = done_q;
  assign ss    = ss_q;
  assign sck   = sck_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_rw.sv
module tb_spi_master_rw;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] freq = 8'd0;
  logic       start_w = 1'b0;
  logic       start_r = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic       done, ss, sck, mosi;
  logic       miso = 1'b0;

  spi_master_rw dut (
    .clk(clk), .rst(rst), .freq(freq), .start_w(start_w), .start_r(start_r),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .ss(ss),
    .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    int          sslen;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor + slave model, sampled on the falling clk edge
  int          frames = 0;
  int          pulses = 0;
  int          sslow = 0;
  int          hrun = 0;
  int          exp_h = 1;
  logic [15:0] bits = 16'h0;
  logic [15:0] slave_word = 16'h0;
  logic [15:0] sreg = 16'h0;
  bit          hrun_bad = 0, bad_idle_sck = 0, bad_done_len = 0;
  bit          sck_prev = 0, done_prev = 0;
  exp_t        e;

  always @(negedge clk) begin
    if (done) begin
      frames++;
      if (sbq.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("mosi_frame", bits, e.frame);
        chk("sck_pulses", pulses, 16);
        chk("ss_low_len", sslow, e.sslen);
        chk("sck_high_len_bad", hrun_bad, 0);
        chk("rdata_at_done", rdata, e.rdata);
      end
    end
    if (done && done_prev) bad_done_len = 1;
    if (ss && sck) bad_idle_sck = 1;
    if (!ss) begin
      sslow++;
      if (sck && !sck_prev) begin
        bits = {bits[14:0], mosi};
        pulses++;
      end
      if (sck) hrun++;
      if (!sck && sck_prev) begin
        if (hrun != exp_h) hrun_bad = 1;
        hrun = 0;
        sreg = sreg << 1;
      end
    end else begin
      sslow = 0; pulses = 0; bits = 16'h0; hrun = 0; hrun_bad = 0;
      sreg = slave_word;
    end
    miso = sreg[15];
    sck_prev = sck;
    done_prev = done;
  end

  task automatic wait_frame(input int maxc);
    int f0;
    int n;
    f0 = frames;
    n = 0;
    while (frames == f0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (frames == f0) chk("frame_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    // Reset with starts low
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ss", ss, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_no_frames", frames, 0);

    // Write, strobe held high for 10 cycles
    exp_h = 5; freq = 8'd4; addr = 7'h2A; wdata = 8'hA5;
    sbq.push_back('{16'h2AA5, 8'h00, 165});
    start_w = 1'b1;
    repeat (10) @(negedge clk);
    start_w = 1'b0;
    wait_frame(400);
    repeat (200) @(negedge clk);
    chk("held_strobe_one_frame", frames, 1);
    chk("write_rdata", rdata, 8'h00);

    // Read with miso = 0
    addr = 7'h15; slave_word = 16'h0000;
    sbq.push_back('{16'h9500, 8'h00, 165});
    start_r = 1'b1; @(negedge clk); start_r = 1'b0;
    wait_frame(400);

    // Fast read, slave returns 0x3C
    exp_h = 1; freq = 8'd0; addr = 7'h7F; slave_word = 16'h003C;
    sbq.push_back('{16'hFF00, 8'h3C, 33});
    start_r = 1'b1; @(negedge clk); start_r = 1'b0;
    wait_frame(100);
    chk("fast_rdata_held", rdata, 8'h3C);

    // Read with a write edge arriving mid-frame
    exp_h = 5; freq = 8'd4; addr = 7'h11; slave_word = 16'h0081;
    sbq.push_back('{16'h9100, 8'h81, 165});
    start_r = 1'b1; @(negedge clk); start_r = 1'b0;
    repeat (20) @(negedge clk);
    freq = 8'd9;
    start_w = 1'b1;
    wait_frame(400);
    start_w = 1'b0;
    freq = 8'd4;
    repeat (200) @(negedge clk);
    chk("busy_edge_ignored", frames, 4);

    // Simultaneous write and read edges: read wins
    addr = 7'h33; wdata = 8'h77; slave_word = 16'h00C3;
    sbq.push_back('{16'hB300, 8'hC3, 165});
    start_w = 1'b1; start_r = 1'b1; @(negedge clk);
    start_w = 1'b0; start_r = 1'b0;
    wait_frame(400);

    // Reset during the 5th sck pulse
    addr = 7'h05; wdata = 8'h5A;
    sbq.push_back('{16'h055A, 8'h00, 165});
    start_w = 1'b1; @(negedge clk); start_w = 1'b0;
    for (int n = 0; n < 200 && pulses < 5; n++) @(negedge clk);
    chk("reached_5th_pulse", pulses, 5);
    rst = 1'b1;
    void'(sbq.pop_back());
    @(negedge clk);
    chk("abort_ss", ss, 1);
    chk("abort_sck", sck, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_done", done, 0);
    chk("abort_rdata", rdata, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", frames, 5);

    // Write after the abort
    addr = 7'h41; wdata = 8'h3E;
    sbq.push_back('{16'h413E, 8'h00, 165});
    start_w = 1'b1; @(negedge clk); start_w = 1'b0;
    wait_frame(400);

    repeat (5) @(negedge clk);
    chk("sck_idle_while_ss_high", bad_idle_sck, 0);
    chk("done_single_cycle", bad_done_len, 0);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
